// File: rtl/debug_apb_master.sv
// Host-command to APB bridge: one transfer at a time, 3 cycles from command accept to response when PREADY is high.
// A stalled host response holds the FSM in RESP; commands are refused (cmd_ready=0) until the response is taken.
module debug_apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic       write;
    logic [4:0] addr;
    logic [7:0] wdata;
  } apb_req_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  apb_req_t   req;
  logic [7:0] wait_cnt;
  logic       timed_out;

  assign timed_out = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are only loaded on accept, so they hold through the whole
  // transfer and keep their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req       <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            req      <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          // Completion wins over timeout in the same cycle.
          if (PREADY) begin
            rsp_rdata <= req.write ? 8'h00 : PRDATA;
            rsp_err   <= 1'b0;
          end else if (timed_out) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PWRITE = req.write;
  assign PADDR  = req.addr;
  assign PWDATA = req.wdata;

endmodule

// File: tb/tb_debug_apb_master.sv
// Directed + randomized transfers against a transaction-level reference of the APB bridge.
module tb_debug_apb_master;

  localparam int TIMEOUT = 16;
  localparam int NO_READY = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  int tests = 0;
  int failed = 0;

  // Peripheral side: a 32-byte register file that stretches ACCESS by wait_lo cycles.
  logic [7:0] slave_mem [32];
  logic [7:0] ref_mem [32];
  int acc_cnt = 0;
  int wait_lo = 0;

  always #5 clk = ~clk;

  assign PREADY = (acc_cnt >= wait_lo);
  assign PRDATA = slave_mem[PADDR];

  always @(posedge clk) begin
    if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
  end

  debug_apb_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete host transaction; expectations come from the transfer rules:
  // wait_lo low cycles then ready, aborted after TIMEOUT low cycles.
  task automatic do_txn(input logic wr, input logic [4:0] addr, input logic [7:0] wd,
                        input int wlo, input int hold);
    bit         exp_err;
    int         exp_acc;
    logic [7:0] exp_rdata;
    int         acc;
    int         lat;
    logic [7:0] held;
    logic       held_err;

    exp_err   = (wlo >= TIMEOUT);
    exp_acc   = exp_err ? TIMEOUT : wlo + 1;
    exp_rdata = (exp_err || wr) ? 8'h00 : ref_mem[addr];
    if (wr && !exp_err) ref_mem[addr] = wd;

    wait_lo   = wlo;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    check("cmd_ready_idle", cmd_ready, 1);
    step();
    // Keep a conflicting command on the bus to show it is ignored mid-transfer.
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wd;
    check("setup_psel", {PSEL, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wd);
    lat = 1;
    acc = 0;
    while (lat < 300) begin
      step();
      lat++;
      if (rsp_valid) break;
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd)
          check("access_stable", {PWRITE, PADDR, PWDATA}, {wr, addr, wd});
      end
    end
    check("rsp_valid_seen", rsp_valid, 1);
    check("access_cycles", acc, exp_acc);
    check("accept_to_rsp", lat, exp_acc + 2);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("resp_psel", {PSEL, PENABLE, cmd_ready}, 3'b000);
    held     = rsp_rdata;
    held_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_state", {rsp_valid, cmd_ready, PSEL}, 3'b100);
      check("hold_data", {held_err, held}, {rsp_err, rsp_rdata});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("after_hs", {rsp_valid, cmd_ready, PSEL}, 3'b010);
    cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[8] = 8'hC3; ref_mem[8] = 8'hC3;
    slave_mem[3] = 8'h11; ref_mem[3] = 8'h11;

    #2;
    check("rst_ctrl", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    check("rst_bus", {PWRITE, PADDR, PWDATA}, 14'h0);
    check("rst_rsp", {rsp_err, rsp_rdata}, 9'h0);
    step();
    step();
    rst = 1'b0;

    do_txn(1'b1, 5'h01, 8'h5A, 0, 0);
    do_txn(1'b0, 5'h01, 8'h00, 0, 0);
    do_txn(1'b0, 5'h08, 8'h00, 1, 0);
    do_txn(1'b0, 5'h1F, 8'h00, NO_READY, 0);
    do_txn(1'b0, 5'h03, 8'h00, TIMEOUT - 1, 0);
    do_txn(1'b1, 5'h03, 8'hA5, TIMEOUT, 1);
    do_txn(1'b0, 5'h03, 8'h00, 2, 5);

    // Reset in the middle of a stalled ACCESS.
    wait_lo   = NO_READY;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h0C;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bus", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    check("async_rst_regs", {PWRITE, PADDR, PWDATA, rsp_err, rsp_rdata}, 23'h0);
    step();
    rst = 1'b0;
    check("post_rst_no_rsp", rsp_valid, 0);
    do_txn(1'b0, 5'h08, 8'h00, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int sel;
      int wlo;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: wlo = 0;
        1: wlo = int'($urandom_range(1, 4));
        2: wlo = int'($urandom_range(5, TIMEOUT - 2));
        3: wlo = TIMEOUT - 1;
        4: wlo = TIMEOUT;
        default: wlo = NO_READY;
      endcase
      do_txn(1'($urandom), 5'($urandom), 8'($urandom), wlo, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/debug_apb_master.md
DEBUG_APB_MASTER -- requirements
Module: debug_apb_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, number of ACCESS cycles with PREADY low before abort (range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  host command present.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-006 SHALL have port: cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-007 SHALL have port: cmd_addr  input  5  debugger register address.
REQ-008 SHALL have port: cmd_wdata  input  8  write data.
REQ-009 SHALL have port: rsp_valid  output  1  response available.
REQ-010 SHALL have port: rsp_ready  input  1  host consumes response.
REQ-011 SHALL have port: rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-012 SHALL have port: rsp_err  output  1  transfer aborted by timeout.
REQ-013 SHALL have port: PSEL  output  1  APB select.
REQ-014 SHALL have port: PENABLE  output  1  APB enable.
REQ-015 SHALL have port: PWRITE  output  1  APB direction.
REQ-016 SHALL have port: PADDR  output  5  APB address.
REQ-017 SHALL have port: PWDATA  output  8  APB write data.
REQ-018 SHALL have port: PRDATA  input  8  APB read data, valid when PREADY high in ACCESS.
REQ-019 SHALL have port: PREADY  input  1  debugger completion; low extends ACCESS.

Function
REQ-020 SHALL implement states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-022 SHALL, on cmd_valid&cmd_ready, register cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and enter SETUP next cycle.
REQ-023 SHALL drive PSEL=1, PENABLE=0 in SETUP for exactly one cycle, then enter ACCESS.
REQ-024 SHALL drive PSEL=1, PENABLE=1 in ACCESS; PADDR/PWRITE/PWDATA SHALL remain stable from SETUP through last ACCESS cycle.
REQ-025 SHALL, when PREADY=1 is sampled in ACCESS, capture PRDATA into rsp_rdata for reads (0 for writes), set rsp_err=0, and enter RESP.
REQ-026 SHALL count ACCESS cycles with PREADY low in an 8-bit counter cleared on entry to SETUP; when PREADY low and count = TIMEOUT-1, SHALL enter RESP with rsp_err=1, rsp_rdata=0.
REQ-027 SHALL give PREADY priority over timeout when both occur in the same cycle (completion, rsp_err=0).
REQ-028 SHALL drive PSEL=0, PENABLE=0 in IDLE and RESP; minimum transfer latency: command accept to rsp_valid = 3 cycles (accept edge, SETUP, ACCESS).
REQ-029 SHALL hold rsp_rdata/rsp_err stable while rsp_valid=1; on rsp_valid&rsp_ready return to IDLE next cycle; no new command accepted in the handshake cycle itself.
REQ-030 SHALL retain PADDR/PWRITE/PWDATA last values in IDLE and RESP.
REQ-031 SHALL ignore cmd_valid outside IDLE and rsp_ready outside RESP.

Reset
REQ-032 SHALL, on rst high, immediately (asynchronously) enter IDLE and force PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, cmd_ready=1 (no response owed for an aborted transfer).
REQ-033 SHALL accept a command on the first rising edge after rst deasserts.

Verification
REQ-034 Write addr 0x01 data 0x5A, PREADY tied high -> SETUP 1 cycle, ACCESS 1 cycle with PWRITE=1 PADDR=0x01 PWDATA=0x5A, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x08, PREADY low first ACCESS cycle then high with PRDATA=0xC3 -> ACCESS lasts 2 cycles, rsp_rdata=0xC3, rsp_err=0, PADDR stable throughout.
REQ-036 Read addr 0x1F, PREADY held low, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, PSEL=0.
REQ-037 PREADY rises in cycle 16 of ACCESS with TIMEOUT=16, PRDATA=0x11 -> rsp_err=0, rsp_rdata=0x11.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, second cmd_valid not accepted until IDLE.
REQ-039 rst asserted mid-ACCESS -> PSEL/PENABLE drop without waiting for a clock edge, no rsp_valid, next command after release completes normally.
